// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit owning HI/LO with modelled multi-cycle latency.
// Define MDU_MADD_EN to enable MADD/MSUB (ops 6/7); otherwise they are no-ops.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {K_SET, K_KEEP, K_ADD, K_SUB} kind_t;

    state_t        state, state_nx;
    logic [CW-1:0] counter;
    logic [63:0]   pending;
    kind_t         pend_kind;

    logic          accept, commit;
    logic [63:0]   res;
    kind_t         res_kind;
    logic          long_op;
    logic [CW-1:0] res_cycles;

    logic [63:0]        sa, sb, ua, ub;
    logic               div_ovf;
    logic [31:0]        sbd, ubd;
    logic signed [31:0] sq, sr;
    logic [31:0]        uq, ur;

    // Divisors are forced to 1 when the result is overridden, so the
    // datapath never evaluates a zero divide or INT_MIN / -1.
    always_comb begin
        sa      = {{32{a[31]}}, a};
        sb      = {{32{b[31]}}, b};
        ua      = {32'd0, a};
        ub      = {32'd0, b};
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sbd     = ((b == 32'd0) || div_ovf) ? 32'd1 : b;
        ubd     = (b == 32'd0) ? 32'd1 : b;
        sq      = $signed(a) / $signed(sbd);
        sr      = $signed(a) % $signed(sbd);
        uq      = a / ubd;
        ur      = a % ubd;
    end

    always_comb begin
        res        = '0;
        res_kind   = K_SET;
        long_op    = 1'b0;
        res_cycles = CW'(MULT_CYCLES);
        case (op)
            OP_MULT: begin
                res     = sa * sb;
                long_op = 1'b1;
            end
            OP_MULTU: begin
                res     = ua * ub;
                long_op = 1'b1;
            end
            OP_DIV: begin
                res        = div_ovf ? {32'd0, 32'h8000_0000} : {sr, sq};
                res_kind   = (b == 32'd0) ? K_KEEP : K_SET;
                long_op    = 1'b1;
                res_cycles = CW'(DIV_CYCLES);
            end
            OP_DIVU: begin
                res        = {ur, uq};
                res_kind   = (b == 32'd0) ? K_KEEP : K_SET;
                long_op    = 1'b1;
                res_cycles = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res      = sa * sb;
                res_kind = K_ADD;
                long_op  = 1'b1;
            end
            OP_MSUB: begin
                res      = sa * sb;
                res_kind = K_SUB;
                long_op  = 1'b1;
            end
`else
            OP_MADD, OP_MSUB: begin
                long_op = 1'b0;
            end
`endif
            default: begin
                long_op = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && long_op) state_nx = RUN;
            RUN:     if (counter == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = start && (state == IDLE);
        commit = (state == RUN) && (counter == CW'(1));
    end

    // Accumulating ops read HI/LO at commit, not at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            pending   <= '0;
            pend_kind <= K_SET;
            hi        <= '0;
            lo        <= '0;
        end else if (accept) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (long_op) begin
                pending   <= res;
                pend_kind <= res_kind;
                counter   <= res_cycles;
            end
        end else if (state == RUN) begin
            counter <= counter - 1'b1;
            if (commit) begin
                case (pend_kind)
                    K_SET:   {hi, lo} <= pending;
                    K_ADD:   {hi, lo} <= {hi, lo} + pending;
                    K_SUB:   {hi, lo} <= {hi, lo} - pending;
                    default: ;
                endcase
            end
        end
    end

endmodule
